// File: rtl/seq_pkg.sv
`default_nettype none
// ============================================================================
// Module  : seq_pkg
// Brief   : Shared constants, loader state encoding and frame helper for the
//           sequencer table loader.
// Rev     : 1.0 - initial release
// ============================================================================
package seq_pkg;

  localparam int FRAME_WORDS = 4;
  localparam int LEN_W       = 16;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_STREAM = 3'd2,
    ST_GAP    = 3'd3,
    ST_COMMIT = 3'd4,
    ST_ERROR  = 3'd5
  } loader_state_e;

  function automatic logic frame_aligned(input logic [31:0] n);
    return (n % FRAME_WORDS) == 0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/seq_table_loader.sv
`default_nettype none
// ============================================================================
// Module  : seq_table_loader
// Brief   : Replays a valid/ready word stream as sequencer table-write strobes
//           with frame alignment, size limit and strobe spacing enforcement.
// Rev     : 1.0 - initial release
// ============================================================================
module seq_table_loader
  import seq_pkg::*;
#(
  parameter int MAX_WORDS = 4096,
  parameter int WSTB_GAP  = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              load_i,
  input  logic              abort_i,
  input  logic [31:0]       data_i,
  input  logic              valid_i,
  input  logic              last_i,
  output logic              ready_o,
  output logic              TABLE_START,
  output logic              TABLE_START_WSTB,
  output logic [31:0]       TABLE_DATA,
  output logic              TABLE_WSTB,
  output logic [LEN_W-1:0]  TABLE_LENGTH,
  output logic              TABLE_LENGTH_WSTB,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o
);

  localparam int          CW       = $clog2(MAX_WORDS) + 1;
  localparam int          GW       = (WSTB_GAP > 1) ? $clog2(WSTB_GAP) : 1;
  localparam logic [CW-1:0] C_MAXC = CW'(MAX_WORDS);
  localparam logic [GW-1:0] C_GAP_INIT = GW'((WSTB_GAP > 0) ? (WSTB_GAP - 1) : 0);

  loader_state_e    state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [GW-1:0]    gap_q, gap_d;
  logic             last_q, last_d;
  logic             err_q, err_d;
  logic [31:0]      data_q, data_d;
  logic             wstb_q, wstb_d;
  logic [LEN_W-1:0] len_q, len_d;
  logic             hs;

  // Abort gates ready combinationally so a coincident word is never taken.
  assign ready_o           = (state_q == ST_STREAM) && !abort_i;
  assign hs                = valid_i && ready_o;
  assign TABLE_START       = (state_q != ST_IDLE);
  assign TABLE_START_WSTB  = (state_q == ST_START);
  assign TABLE_DATA        = data_q;
  assign TABLE_WSTB        = wstb_q;
  assign TABLE_LENGTH      = len_q;
  assign TABLE_LENGTH_WSTB = (state_q == ST_COMMIT) && !abort_i;
  assign done_o            = (state_q == ST_COMMIT) && !abort_i;
  assign busy_o            = (state_q != ST_IDLE);
  assign err_o             = err_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    gap_d   = gap_q;
    last_d  = last_q;
    err_d   = err_q;
    data_d  = data_q;
    wstb_d  = 1'b0;
    len_d   = len_q;

    case (state_q)
      ST_IDLE: begin
        if (load_i) begin
          state_d = ST_START;
          cnt_d   = '0;
          last_d  = 1'b0;
          err_d   = 1'b0;
        end
      end
      ST_START: state_d = ST_STREAM;
      ST_STREAM: begin
        if (hs) begin
          if (cnt_q == C_MAXC) begin
            state_d = ST_ERROR;
          end else begin
            data_d = data_i;
            wstb_d = 1'b1;
            cnt_d  = cnt_q + CW'(1);
            if (last_i && !frame_aligned(32'(cnt_d))) begin
              state_d = ST_ERROR;
            end else if (WSTB_GAP > 0) begin
              state_d = ST_GAP;
              gap_d   = C_GAP_INIT;
              last_d  = last_i;
            end else begin
              state_d = last_i ? ST_COMMIT : ST_STREAM;
            end
          end
        end
      end
      ST_GAP: begin
        if (gap_q == '0) begin
          state_d = last_q ? ST_COMMIT : ST_STREAM;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      ST_COMMIT: state_d = ST_IDLE;
      ST_ERROR: begin
        state_d = ST_IDLE;
        err_d   = 1'b1;
      end
      default: state_d = ST_IDLE;
    endcase

    if (abort_i && (state_q != ST_IDLE)) begin
      state_d = ST_IDLE;
      err_d   = err_q;
    end

    // Length is captured on entry so it is stable while the commit strobe is high.
    if ((state_d == ST_COMMIT) && (state_q != ST_COMMIT)) begin
      len_d = LEN_W'(32'(cnt_d));
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      gap_q   <= '0;
      last_q  <= 1'b0;
      err_q   <= 1'b0;
      data_q  <= '0;
      wstb_q  <= 1'b0;
      len_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      gap_q   <= gap_d;
      last_q  <= last_d;
      err_q   <= err_d;
      data_q  <= data_d;
      wstb_q  <= wstb_d;
      len_q   <= len_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_seq_table_loader.sv
`default_nettype none
// ============================================================================
// Module  : tb_seq_table_loader
// Brief   : Directed self-checking bench for seq_table_loader.
// Rev     : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_seq_table_loader;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: back-to-back strobes, small table for overflow checks
  logic        load0 = 0, abort0 = 0, valid0 = 0, last0 = 0;
  logic [31:0] data0 = 0;
  logic        rdy0, st0, stw0, wstb0, lwstb0, busy0, done0, err0;
  logic [31:0] tdata0;
  logic [15:0] tlen0;

  // Instance 1: two idle cycles after every strobe
  logic        load1 = 0, abort1 = 0, valid1 = 0, last1 = 0;
  logic [31:0] data1 = 0;
  logic        rdy1, st1, stw1, wstb1, lwstb1, busy1, done1, err1;
  logic [31:0] tdata1;
  logic [15:0] tlen1;

  seq_table_loader #(.MAX_WORDS(8), .WSTB_GAP(0)) u_dut0 (
    .clk_i(clk), .reset_i(rst), .load_i(load0), .abort_i(abort0),
    .data_i(data0), .valid_i(valid0), .last_i(last0), .ready_o(rdy0),
    .TABLE_START(st0), .TABLE_START_WSTB(stw0), .TABLE_DATA(tdata0),
    .TABLE_WSTB(wstb0), .TABLE_LENGTH(tlen0), .TABLE_LENGTH_WSTB(lwstb0),
    .busy_o(busy0), .done_o(done0), .err_o(err0)
  );

  seq_table_loader #(.MAX_WORDS(4096), .WSTB_GAP(2)) u_dut1 (
    .clk_i(clk), .reset_i(rst), .load_i(load1), .abort_i(abort1),
    .data_i(data1), .valid_i(valid1), .last_i(last1), .ready_o(rdy1),
    .TABLE_START(st1), .TABLE_START_WSTB(stw1), .TABLE_DATA(tdata1),
    .TABLE_WSTB(wstb1), .TABLE_LENGTH(tlen1), .TABLE_LENGTH_WSTB(lwstb1),
    .busy_o(busy1), .done_o(done1), .err_o(err1)
  );

  int wstb_cnt0 = 0, lwstb_cnt0 = 0;
  always @(negedge clk) begin
    if (wstb0)  wstb_cnt0++;
    if (lwstb0) lwstb_cnt0++;
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Starts a load on instance 0 and leaves the bench in the first STREAM cycle.
  task automatic load_dut0(input string tag);
    load0 = 1'b1;
    tick();
    load0 = 1'b0;
    @(negedge clk);
    chk({tag, "_start_wstb"}, 32'(stw0), 32'd1);
    chk({tag, "_err_clr"}, 32'(err0), 32'd0);
    tick();
  endtask

  task automatic send_words0(input int n, input bit with_last, input int base);
    for (int i = 1; i <= n; i++) begin
      data0  = base + i;
      valid0 = 1'b1;
      last0  = with_last && (i == n);
      @(negedge clk);
      chk("ready_stream", 32'(rdy0), 32'd1);
      tick();
    end
    valid0 = 1'b0;
    last0  = 1'b0;
  endtask

  int base_w, base_l, wi;
  logic [12:0] rv, wv, cv;
  logic [15:0] glen;
  logic        ghs;

  initial begin
    rst = 1'b1;
    #12;
    @(negedge clk);
    chk("rst_start", 32'(st0), 32'd0);
    chk("rst_busy", 32'(busy0), 32'd0);
    chk("rst_ready", 32'(rdy0), 32'd0);
    chk("rst_data", tdata0, 32'd0);
    chk("rst_len", 32'(tlen0), 32'd0);
    chk("rst_err", 32'(err0), 32'd0);
    rst = 1'b0;
    tick();

    // Nominal 8-word load, no gap
    load0 = 1'b1;
    @(negedge clk);
    chk("idle_ready", 32'(rdy0), 32'd0);
    chk("idle_start_wstb", 32'(stw0), 32'd0);
    tick();
    load0 = 1'b0;
    @(negedge clk);
    chk("nom_start_wstb", 32'(stw0), 32'd1);
    chk("nom_start_lvl", 32'(st0), 32'd1);
    chk("nom_busy", 32'(busy0), 32'd1);
    tick();
    for (int i = 1; i <= 8; i++) begin
      data0  = i;
      valid0 = 1'b1;
      last0  = (i == 8);
      @(negedge clk);
      chk("nom_ready", 32'(rdy0), 32'd1);
      if (i > 1) begin
        chk("nom_wstb", 32'(wstb0), 32'd1);
        chk("nom_data", tdata0, 32'(i - 1));
      end
      tick();
    end
    valid0 = 1'b0;
    last0  = 1'b0;
    @(negedge clk);
    chk("nom_wstb8", 32'(wstb0), 32'd1);
    chk("nom_data8", tdata0, 32'd8);
    chk("nom_lwstb", 32'(lwstb0), 32'd1);
    chk("nom_len", 32'(tlen0), 32'd8);
    chk("nom_done", 32'(done0), 32'd1);
    tick();
    @(negedge clk);
    chk("nom_busy_after", 32'(busy0), 32'd0);
    chk("nom_done_after", 32'(done0), 32'd0);
    chk("nom_start_after", 32'(st0), 32'd0);
    chk("nom_err_after", 32'(err0), 32'd0);
    tick();

    // Gap pacing on instance 1: ready 1,0,0 repeating; strobes 3 apart
    load1 = 1'b1;
    tick();
    load1 = 1'b0;
    tick();
    wi = 1;
    valid1 = 1'b1;
    data1  = 32'h11;
    last1  = 1'b0;
    for (int c = 0; c < 13; c++) begin
      @(negedge clk);
      rv[c] = rdy1;
      wv[c] = wstb1;
      cv[c] = lwstb1;
      if (c == 12) glen = tlen1;
      ghs = valid1 && rdy1;
      tick();
      if (ghs) begin
        wi++;
        if (wi > 4) begin
          valid1 = 1'b0;
          last1  = 1'b0;
        end else begin
          data1 = 32'h10 + wi;
          last1 = (wi == 4);
        end
      end
    end
    chk("gap_ready_pat", 32'(rv), 32'h0249);
    chk("gap_wstb_pat", 32'(wv), 32'h0492);
    chk("gap_commit_pat", 32'(cv), 32'h1000);
    chk("gap_len", 32'(glen), 32'd4);
    chk("gap_data", tdata1, 32'h14);

    // Partial frame: 6 words, last on word 6
    base_w = wstb_cnt0;
    base_l = lwstb_cnt0;
    load_dut0("part");
    send_words0(6, 1'b1, 32'h100);
    tick();
    tick();
    @(negedge clk);
    chk("part_wstb_n", 32'(wstb_cnt0 - base_w), 32'd6);
    chk("part_lwstb_n", 32'(lwstb_cnt0 - base_l), 32'd0);
    chk("part_err", 32'(err0), 32'd1);
    chk("part_busy", 32'(busy0), 32'd0);
    tick(); tick(); tick();
    @(negedge clk);
    chk("part_err_sticky", 32'(err0), 32'd1);
    tick();

    // Overflow: 9 words into an 8-word table; error cleared by this load
    base_w = wstb_cnt0;
    base_l = lwstb_cnt0;
    load_dut0("ovf");
    send_words0(9, 1'b0, 0);
    tick();
    tick();
    @(negedge clk);
    chk("ovf_wstb_n", 32'(wstb_cnt0 - base_w), 32'd8);
    chk("ovf_lwstb_n", 32'(lwstb_cnt0 - base_l), 32'd0);
    chk("ovf_data_hold", tdata0, 32'd8);
    chk("ovf_err", 32'(err0), 32'd1);
    chk("ovf_busy", 32'(busy0), 32'd0);
    tick();

    // Abort coincident with word 4
    base_w = wstb_cnt0;
    base_l = lwstb_cnt0;
    load_dut0("abt");
    send_words0(3, 1'b0, 0);
    data0  = 32'd4;
    valid0 = 1'b1;
    abort0 = 1'b1;
    @(negedge clk);
    chk("abt_ready_gate", 32'(rdy0), 32'd0);
    tick();
    abort0 = 1'b0;
    valid0 = 1'b0;
    @(negedge clk);
    chk("abt_busy", 32'(busy0), 32'd0);
    chk("abt_err", 32'(err0), 32'd0);
    chk("abt_data", tdata0, 32'd3);
    chk("abt_wstb_n", 32'(wstb_cnt0 - base_w), 32'd3);
    chk("abt_lwstb_n", 32'(lwstb_cnt0 - base_l), 32'd0);
    tick();
    load_dut0("reload");
    send_words0(4, 1'b1, 32'h20);
    @(negedge clk);
    chk("reload_lwstb", 32'(lwstb0), 32'd1);
    chk("reload_len", 32'(tlen0), 32'd4);
    chk("reload_done", 32'(done0), 32'd1);
    chk("reload_data", tdata0, 32'h24);
    tick();

    // Asynchronous reset mid-stream
    load_dut0("rstm");
    send_words0(2, 1'b0, 32'h30);
    data0  = 32'h33;
    valid0 = 1'b1;
    #2;
    rst = 1'b1;
    #1;
    chk("rstm_start", 32'(st0), 32'd0);
    chk("rstm_data", tdata0, 32'd0);
    chk("rstm_wstb", 32'(wstb0), 32'd0);
    chk("rstm_busy", 32'(busy0), 32'd0);
    chk("rstm_ready", 32'(rdy0), 32'd0);
    valid0 = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    load_dut0("rstm_new");
    @(negedge clk);
    chk("rstm_new_ready", 32'(rdy0), 32'd1);
    chk("rstm_new_start", 32'(st0), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
